// File: rtl/battleship_pkg.sv
// Shared constants, evaluator state encoding and cell indexing for the battleship shot evaluator.
package battleship_pkg;

    localparam int DEF_GRID_W    = 8;
    localparam int DEF_GRID_H    = 8;
    localparam int DEF_NUM_SHIPS = 5;
    localparam int DEF_MAX_TURNS = 40;
    localparam int ID_W          = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_EVAL  = 2'd3
    } eval_state_t;

    function automatic int cell_index(input int x, input int y, input int grid_w);
        return y * grid_w + x;
    endfunction

endpackage

// File: rtl/battleship_fired_map.sv
// One bit per board cell recording whether that cell has already been shot at.
module battleship_fired_map
    import battleship_pkg::*;
#(
    parameter int CELLS = DEF_GRID_W * DEF_GRID_H,
    parameter int IDX_W = $clog2(CELLS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_bit
);

    logic [CELLS-1:0] r_fired;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fired <= '0;
        end else begin
            if (i_clr_en) r_fired[i_clr_idx] <= 1'b0;
            if (i_set_en) r_fired[i_set_idx] <= 1'b1;
        end
    end

    assign o_rd_bit = r_fired[i_rd_idx];

endmodule

// File: rtl/battleship_shot_eval.sv
// Board/shot evaluator feeding the game-control FSM: loads the layout, resolves shots, tracks turns.
// Optional feature: define BATTLESHIP_BONUS_TURN_EN so that only misses consume a turn.
module battleship_shot_eval
    import battleship_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int NUM_SHIPS = DEF_NUM_SHIPS,
    parameter int MAX_TURNS = DEF_MAX_TURNS,
    localparam int X_W      = $clog2(GRID_W),
    localparam int Y_W      = $clog2(GRID_H),
    localparam int CELLS    = GRID_W * GRID_H,
    localparam int T_W      = $clog2(MAX_TURNS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_restart,
    input  logic                  i_fire,
    input  logic [X_W-1:0]        i_cursor_x,
    input  logic [Y_W-1:0]        i_cursor_y,
    input  logic [CELLS*ID_W-1:0] i_ship_id_map,
    output logic                  o_ready,
    output logic                  o_shot_select,
    output logic                  o_hit,
    output logic                  o_repeat_shot,
    output logic                  o_sunk_pulse,
    output logic [ID_W-1:0]       o_sunk_id,
    output logic                  o_all_ships_sunk,
    output logic                  o_turns_exhausted,
    output logic [T_W-1:0]        o_turns_left
);

    localparam int IDX_W   = $clog2(CELLS);
    localparam int CNT_W   = $clog2(CELLS + 1);
    localparam int SL_W    = $clog2(NUM_SHIPS + 1);
    localparam int NUM_IDS = 1 << ID_W;

    eval_state_t      r_state;
    eval_state_t      w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cell;
    logic [IDX_W-1:0] w_cursor_idx;
    logic [ID_W-1:0]  r_board [CELLS];
    logic [CNT_W-1:0] r_remaining [NUM_IDS];
    logic [SL_W-1:0]  r_ships_left;
    logic [T_W-1:0]   r_turns_left;
    logic [ID_W-1:0]  w_raw_id;
    logic [ID_W-1:0]  w_load_id;
    logic [ID_W-1:0]  w_eval_id;
    logic [ID_W-1:0]  r_sunk_id;
    logic             r_fire_q;
    logic             r_fire_d;
    logic             w_fire_edge;
    logic             w_in_range;
    logic             w_fire_accept;
    logic             w_fired_bit;
    logic             w_ready;
    logic             r_hit;
    logic             r_shot_select;
    logic             r_repeat_shot;
    logic             r_sunk_pulse;
    logic             r_loaded;

    // Ids above NUM_SHIPS are folded to water while loading so EVAL never sees them.
    assign w_raw_id      = i_ship_id_map[int'(r_idx) * ID_W +: ID_W];
    assign w_load_id     = (w_raw_id > ID_W'(NUM_SHIPS)) ? '0 : w_raw_id;
    assign w_eval_id     = r_board[r_cell];
    assign w_cursor_idx  = IDX_W'(cell_index(int'(i_cursor_x), int'(i_cursor_y), GRID_W));
    assign w_in_range    = (int'(i_cursor_x) < GRID_W) && (int'(i_cursor_y) < GRID_H);
    assign w_fire_edge   = r_fire_q & ~r_fire_d;
    assign w_fire_accept = w_fire_edge & w_in_range & (r_turns_left != '0);

    battleship_fired_map #(
        .CELLS (CELLS),
        .IDX_W (IDX_W)
    ) u_fired_map (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr_en  ((r_state == S_LOAD) && !i_restart),
        .i_clr_idx (r_idx),
        .i_set_en  ((r_state == S_EVAL) && !i_restart && !w_fired_bit),
        .i_set_idx (r_cell),
        .i_rd_idx  (r_cell),
        .o_rd_bit  (w_fired_bit)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_fire_q <= 1'b0;
            r_fire_d <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_fire_q <= i_fire;
            r_fire_d <= r_fire_q;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_restart) begin
            w_next_state = S_LOAD;
        end else begin
            unique case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_LOAD:  if (r_idx == IDX_W'(CELLS - 1)) w_next_state = S_READY;
                S_READY: if (w_fire_accept) w_next_state = S_EVAL;
                S_EVAL:  w_next_state = S_READY;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready = (r_state == S_READY);
    end

    // Layout load, shot resolution and the held/pulsed result registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx         <= '0;
            r_cell        <= '0;
            r_ships_left  <= '0;
            r_turns_left  <= T_W'(MAX_TURNS);
            r_hit         <= 1'b0;
            r_sunk_id     <= '0;
            r_shot_select <= 1'b0;
            r_repeat_shot <= 1'b0;
            r_sunk_pulse  <= 1'b0;
            r_loaded      <= 1'b0;
            for (int i = 0; i < CELLS; i++) r_board[i] <= '0;
            for (int i = 0; i < NUM_IDS; i++) r_remaining[i] <= '0;
        end else begin
            r_shot_select <= 1'b0;
            r_repeat_shot <= 1'b0;
            r_sunk_pulse  <= 1'b0;
            if (i_restart) begin
                r_idx        <= '0;
                r_ships_left <= '0;
                r_turns_left <= T_W'(MAX_TURNS);
                r_hit        <= 1'b0;
                r_sunk_id    <= '0;
                r_loaded     <= 1'b0;
                for (int i = 0; i < NUM_IDS; i++) r_remaining[i] <= '0;
            end else begin
                unique case (r_state)
                    S_LOAD: begin
                        r_board[r_idx] <= w_load_id;
                        if (w_load_id != '0) begin
                            r_remaining[w_load_id] <= r_remaining[w_load_id] + CNT_W'(1);
                            if (r_remaining[w_load_id] == '0)
                                r_ships_left <= r_ships_left + SL_W'(1);
                        end
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(CELLS - 1)) r_loaded <= 1'b1;
                    end
                    S_READY: begin
                        if (w_fire_accept) r_cell <= w_cursor_idx;
                    end
                    S_EVAL: begin
                        if (w_fired_bit) begin
                            r_repeat_shot <= 1'b1;
                        end else begin
                            r_shot_select <= 1'b1;
                            r_hit         <= (w_eval_id != '0);
`ifdef BATTLESHIP_BONUS_TURN_EN
                            if ((w_eval_id == '0) && (r_turns_left != '0))
                                r_turns_left <= r_turns_left - T_W'(1);
`else
                            if (r_turns_left != '0)
                                r_turns_left <= r_turns_left - T_W'(1);
`endif
                            if (w_eval_id != '0) begin
                                r_remaining[w_eval_id] <= r_remaining[w_eval_id] - CNT_W'(1);
                                if (r_remaining[w_eval_id] == CNT_W'(1)) begin
                                    r_sunk_pulse <= 1'b1;
                                    r_sunk_id    <= w_eval_id;
                                    r_ships_left <= r_ships_left - SL_W'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ready           = w_ready;
    assign o_shot_select     = r_shot_select;
    assign o_hit             = r_hit;
    assign o_repeat_shot     = r_repeat_shot;
    assign o_sunk_pulse      = r_sunk_pulse;
    assign o_sunk_id         = r_sunk_id;
    assign o_all_ships_sunk  = r_loaded && (r_ships_left == '0);
    assign o_turns_exhausted = (r_turns_left == '0);
    assign o_turns_left      = r_turns_left;

endmodule

// File: tb/tb_battleship_shot_eval.sv
// Self-checking bench for battleship_shot_eval: directed game steps plus random games against a board model.
module tb_battleship_shot_eval;
    import battleship_pkg::*;

    localparam int GW    = DEF_GRID_W;
    localparam int GH    = DEF_GRID_H;
    localparam int NS    = DEF_NUM_SHIPS;
    localparam int MT    = DEF_MAX_TURNS;
    localparam int CELLS = GW * GH;
    localparam int T_W   = $clog2(MT + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  restart;
    logic                  fire;
    logic [2:0]            cx;
    logic [2:0]            cy;
    logic [CELLS*ID_W-1:0] shipMap;
    logic                  o_ready, o_shot_select, o_hit, o_repeat_shot, o_sunk_pulse;
    logic [ID_W-1:0]       o_sunk_id;
    logic                  o_all_ships_sunk, o_turns_exhausted;
    logic [T_W-1:0]        o_turns_left;

    int checks = 0;
    int errors = 0;

    int board [CELLS];
    bit fired [CELLS];
    int remaining [8];
    int mTurns;
    bit mHit;
    int mSunkId;
    bit mLoaded;

    battleship_shot_eval dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_restart         (restart),
        .i_fire            (fire),
        .i_cursor_x        (cx),
        .i_cursor_y        (cy),
        .i_ship_id_map     (shipMap),
        .o_ready           (o_ready),
        .o_shot_select     (o_shot_select),
        .o_hit             (o_hit),
        .o_repeat_shot     (o_repeat_shot),
        .o_sunk_pulse      (o_sunk_pulse),
        .o_sunk_id         (o_sunk_id),
        .o_all_ships_sunk  (o_all_ships_sunk),
        .o_turns_exhausted (o_turns_exhausted),
        .o_turns_left      (o_turns_left)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int shipsLeft();
        int n = 0;
        for (int i = 1; i <= NS; i++) if (remaining[i] > 0) n++;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkLevels(input string tag);
        checkOutput({tag, ".hit"}, 32'(o_hit), 32'(mHit));
        checkOutput({tag, ".sunk_id"}, 32'(o_sunk_id), mSunkId);
        checkOutput({tag, ".all_sunk"}, 32'(o_all_ships_sunk), 32'(mLoaded && shipsLeft() == 0));
        checkOutput({tag, ".exhausted"}, 32'(o_turns_exhausted), 32'(mTurns == 0));
        checkOutput({tag, ".turns_left"}, 32'(o_turns_left), mTurns);
    endtask

    task automatic modelLoad();
        int id;
        for (int i = 0; i < 8; i++) remaining[i] = 0;
        for (int i = 0; i < CELLS; i++) begin
            id = int'(shipMap[i*ID_W +: ID_W]);
            if (id > NS) id = 0;
            board[i] = id;
            fired[i] = 1'b0;
            if (id != 0) remaining[id]++;
        end
        mTurns = MT; mHit = 1'b0; mSunkId = 0; mLoaded = 1'b1;
    endtask

    // Restart, optionally restart again mid-load with fire toggling, and time how long until ready.
    task automatic loadLayout(input bit midRestart);
        int n, pulses;
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        if (midRestart) begin
            fire = 1'b1;
            repeat (10) @(negedge clk);
            restart = 1'b1;
            @(negedge clk); restart = 1'b0;
        end
        n = 0; pulses = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (o_shot_select || o_repeat_shot || o_sunk_pulse) pulses++;
            if (n == 5) fire = 1'b0;
            if (o_ready) break;
        end
        checkOutput("load.cycles", n, CELLS);
        checkOutput("load.pulses", pulses, 0);
        modelLoad();
        checkLevels("load");
    endtask

    // One fire press held for several cycles; results expected exactly two cycles after the edge sample.
    task automatic applyStimulus(input int x, input int y);
        int c, id;
        bit expShot, expRep, expSunk;
        c = y * GW + x;
        expShot = 1'b0; expRep = 1'b0; expSunk = 1'b0;
        if (mLoaded && mTurns > 0) begin
            if (fired[c]) begin
                expRep = 1'b1;
            end else begin
                fired[c] = 1'b1;
                expShot = 1'b1;
                id = board[c];
                mHit = (id != 0);
`ifdef BATTLESHIP_BONUS_TURN_EN
                if (!mHit) mTurns--;
`else
                mTurns--;
`endif
                if (mHit) begin
                    remaining[id]--;
                    if (remaining[id] == 0) begin
                        expSunk = 1'b1;
                        mSunkId = id;
                    end
                end
            end
        end
        @(negedge clk); cx = 3'(x); cy = 3'(y); fire = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("early.pulses", 32'({o_shot_select, o_repeat_shot, o_sunk_pulse}), 0);
        end
        @(posedge clk); #1;
        checkOutput("shot.shot_select", 32'(o_shot_select), 32'(expShot));
        checkOutput("shot.repeat_shot", 32'(o_repeat_shot), 32'(expRep));
        checkOutput("shot.sunk_pulse", 32'(o_sunk_pulse), 32'(expSunk));
        checkLevels("shot");
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("held.pulses", 32'({o_shot_select, o_repeat_shot, o_sunk_pulse}), 0);
            checkLevels("held");
        end
        @(negedge clk); fire = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int shots;
        reset = 1'b1; restart = 1'b0; fire = 1'b0; cx = '0; cy = '0; shipMap = '0;
        mTurns = MT; mHit = 1'b0; mSunkId = 0; mLoaded = 1'b0;
        for (int i = 0; i < 8; i++) remaining[i] = 0;
        #23 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.ready", 32'(o_ready), 0);
        checkOutput("reset.pulses", 32'({o_shot_select, o_repeat_shot, o_sunk_pulse}), 0);
        checkLevels("reset");

        shipMap = '0;
        shipMap[0 +: ID_W] = 3'd1;
        shipMap[ID_W +: ID_W] = 3'd1;
        loadLayout(1'b0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(5, 6);

        shipMap = '0;
        loadLayout(1'b1);
        applyStimulus(0, 0);
        applyStimulus(7, 7);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < CELLS; i++)
                shipMap[i*ID_W +: ID_W] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            loadLayout(1'b0);
            shots = 0;
            while (mTurns > 0 && shots < 150) begin
                applyStimulus($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
                shots++;
            end
            applyStimulus($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
